// File: rtl/sdram_port_bridge_pkg.sv
// Shared definitions for the SDRAM client port bridge: default widths,
// address/data types, read FSM encoding and a rising-edge helper.
// Build option: SDRAM_BRIDGE_RAW_CHECK_EN (used by sdram_port_bridge).
package sdram_bridge_pkg;

  localparam int DEF_ADDR_W = 20;
  localparam int DEF_DATA_W = 16;

  typedef logic [DEF_ADDR_W-1:0] addr_t;
  typedef logic [DEF_DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_WAIT = 2'd2
  } rd_state_e;

  // The controller holds gnt / read_valid for several cycles; only the first
  // cycle of each assertion carries meaning for the bridge.
  function automatic logic edge_rise(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/sdram_port_bridge_if.sv
// Client and controller signal bundle for sdram_port_bridge.
// slave  : the bridge view (takes client requests, drives the controller).
// master : the environment view (client plus controller).
interface sdram_port_bridge_if
  import sdram_bridge_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  // Client write port
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  // Client read port
  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_resp_valid;
  logic [DATA_W-1:0] rd_resp_data;
  // Controller write channel
  logic              write_req;
  logic              write_gnt;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] din;
  // Controller read channel
  logic              read_req;
  logic              read_gnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] dout;
  logic              read_valid;

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
           write_gnt, read_gnt, dout, read_valid,
    output wr_ready, rd_ready, rd_resp_valid, rd_resp_data,
           write_req, w_addr, din, read_req, r_addr
  );

  modport master (
    output wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
           write_gnt, read_gnt, dout, read_valid,
    input  wr_ready, rd_ready, rd_resp_valid, rd_resp_data,
           write_req, w_addr, din, read_req, r_addr
  );

endinterface

// File: rtl/sdram_port_bridge_wr_fifo.sv
// Posted-write FIFO for the SDRAM bridge. Head entry is always visible; a
// per-entry valid/address view lets the bridge look for read-after-write hits.
// Push is refused when full even if a pop happens in the same cycle.
module sdram_wr_fifo
  import sdram_bridge_pkg::*;
#(
  parameter int  DEPTH  = 4,
  parameter int  ADDR_W = DEF_ADDR_W,
  parameter int  DATA_W = DEF_DATA_W,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int LVL_W  = PTR_W + 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push_i,
  input  logic [ADDR_W-1:0]            push_addr_i,
  input  logic [DATA_W-1:0]            push_data_i,
  input  logic                         pop_i,
  output logic [ADDR_W-1:0]            head_addr_o,
  output logic [DATA_W-1:0]            head_data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [LVL_W-1:0]             level_o,
  output logic [DEPTH-1:0]             entry_vld_o,
  output logic [DEPTH-1:0][ADDR_W-1:0] entry_addr_o
);

  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]            level_q, level_d;
  logic [DEPTH-1:0]            vld_q, vld_d;
  logic [DEPTH-1:0][ADDR_W-1:0] addr_mem;
  logic [DATA_W-1:0]           data_mem [DEPTH];
  logic                        push_ok, pop_ok;

  assign full_o       = (level_q == LVL_W'(DEPTH));
  assign empty_o      = (level_q == '0);
  assign push_ok      = push_i & ~full_o;
  assign pop_ok       = pop_i & ~empty_o;
  assign level_o      = level_q;
  assign entry_vld_o  = vld_q;
  assign entry_addr_o = addr_mem;
  assign head_addr_o  = addr_mem[rd_ptr_q];
  assign head_data_o  = data_mem[rd_ptr_q];

  // Pointer, occupancy and per-entry valid update
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    vld_d    = vld_q;
    if (push_ok) begin
      wr_ptr_d        = wr_ptr_q + 1'b1;
      vld_d[wr_ptr_q] = 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d        = rd_ptr_q + 1'b1;
      vld_d[rd_ptr_q] = 1'b0;
    end
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Control state register; reset empties the FIFO
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      vld_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      vld_q    <= vld_d;
    end
  end

  // Entry storage; contents are qualified by vld_q so no reset is needed
  always_ff @(posedge clk) begin
    if (push_ok) begin
      addr_mem[wr_ptr_q] <= push_addr_i;
      data_mem[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/sdram_port_bridge.sv
// Client-side front end for the dual-ported SDRAM controller. Writes are
// posted into sdram_wr_fifo and drained on write_gnt rising edges; single
// reads run through a three-state FSM against the level req/gnt handshake.
// Build option: SDRAM_BRIDGE_RAW_CHECK_EN holds off a read whose address
// matches any posted write still in the FIFO.
module sdram_port_bridge
  import sdram_bridge_pkg::*;
#(
  parameter int  WFIFO_DEPTH = 4,
  parameter int  ADDR_W      = DEF_ADDR_W,
  parameter int  DATA_W      = DEF_DATA_W,
  localparam int LVL_W       = $clog2(WFIFO_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset_n,
  sdram_port_bridge_if.slave bus,
  output logic [LVL_W-1:0]   wfifo_level
);

  logic                              wgnt_q, rgnt_q, rv_q;
  logic                              wgnt_rise, rgnt_rise, rv_rise;
  logic                              fifo_full, fifo_empty, fifo_pop;
  logic [WFIFO_DEPTH-1:0]            entry_vld;
  logic [WFIFO_DEPTH-1:0][ADDR_W-1:0] entry_addr;
  logic                              raw_hit;
  rd_state_e                         state_q, state_d;
  logic                              rd_accept, resp_fire;
  logic                              read_req_c, rd_ready_c;
  logic [ADDR_W-1:0]                 r_addr_q;
  logic [DATA_W-1:0]                 rd_resp_data_q;
  logic                              rd_resp_valid_q;

  // Edge history for the controller's stretched handshake signals
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wgnt_q <= 1'b0;
      rgnt_q <= 1'b0;
      rv_q   <= 1'b0;
    end else begin
      wgnt_q <= bus.write_gnt;
      rgnt_q <= bus.read_gnt;
      rv_q   <= bus.read_valid;
    end
  end

  assign wgnt_rise = edge_rise(bus.write_gnt, wgnt_q);
  assign rgnt_rise = edge_rise(bus.read_gnt, rgnt_q);
  assign rv_rise   = edge_rise(bus.read_valid, rv_q);

  // A grant edge only pops when a write was actually being requested
  assign fifo_pop  = wgnt_rise & ~fifo_empty;

  sdram_wr_fifo #(
    .DEPTH  (WFIFO_DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wr_fifo (
    .clk          (clk),
    .reset_n      (reset_n),
    .push_i       (bus.wr_valid),
    .push_addr_i  (bus.wr_addr),
    .push_data_i  (bus.wr_data),
    .pop_i        (fifo_pop),
    .head_addr_o  (bus.w_addr),
    .head_data_o  (bus.din),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .level_o      (wfifo_level),
    .entry_vld_o  (entry_vld),
    .entry_addr_o (entry_addr)
  );

  assign bus.wr_ready  = ~fifo_full;
  assign bus.write_req = ~fifo_empty;

`ifdef SDRAM_BRIDGE_RAW_CHECK_EN
  // Read-after-write hazard: any posted write to the same word blocks the read
  always_comb begin
    raw_hit = 1'b0;
    for (int i = 0; i < WFIFO_DEPTH; i++) begin
      if (entry_vld[i] && (entry_addr[i] == bus.rd_addr)) raw_hit = 1'b1;
    end
  end
`else
  logic raw_unused;
  assign raw_hit    = 1'b0;
  assign raw_unused = ^{entry_vld, entry_addr};
`endif

  // Read FSM state register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= R_IDLE;
    else          state_q <= state_d;
  end

  // Read FSM next state and handshake outputs
  always_comb begin
    state_d    = state_q;
    rd_accept  = 1'b0;
    resp_fire  = 1'b0;
    read_req_c = 1'b0;
    rd_ready_c = 1'b0;
    unique case (state_q)
      R_IDLE: begin
        rd_ready_c = ~raw_hit;
        if (bus.rd_valid && !raw_hit) begin
          rd_accept = 1'b1;
          state_d   = R_REQ;
        end
      end
      R_REQ: begin
        read_req_c = 1'b1;
        if (rgnt_rise) state_d = R_WAIT;
      end
      R_WAIT: begin
        if (rv_rise) begin
          resp_fire = 1'b1;
          state_d   = R_IDLE;
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  // Latched read address and the one-cycle response
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_addr_q        <= '0;
      rd_resp_data_q  <= '0;
      rd_resp_valid_q <= 1'b0;
    end else begin
      rd_resp_valid_q <= resp_fire;
      if (rd_accept) r_addr_q       <= bus.rd_addr;
      if (resp_fire) rd_resp_data_q <= bus.dout;
    end
  end

  assign bus.rd_ready      = rd_ready_c;
  assign bus.read_req      = read_req_c;
  assign bus.r_addr        = r_addr_q;
  assign bus.rd_resp_valid = rd_resp_valid_q;
  assign bus.rd_resp_data  = rd_resp_data_q;

endmodule
